// File: rtl/imem_rom.sv
// -----------------------------------------------------------------------------
// imem_rom
//
// Instruction ROM for the fetch stage of the pipelined processor. It holds
// 64 words of 32 bits each and is addressed by word index, not by byte
// address. Indices 0..46 hold the program. Every index from 47 to 63 reads
// as zero.
//
// Ports:
//   clk    in   1   sole clock; q_r updates on the rising edge
//   rst_n  in   1   asynchronous, active-low reset (clears q_r only)
//   addr   in   6   word index 0..63
//   q      out  32  combinational read data, ROM[addr]
//   q_r    out  32  q registered one clock later
//   oob    out  1   (only with IMEM_OOB_FLAG_EN) addr is past the program
//
// Optional feature: define IMEM_OOB_FLAG_EN to add the combinational oob
// flag. When the macro is undefined, the port is absent.
// -----------------------------------------------------------------------------
module imem_rom #(
  localparam int N_WORDS = 64,
  localparam int N_PROG  = 47,
  localparam int AW      = $clog2(N_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
`ifdef IMEM_OOB_FLAG_EN
  output logic          oob,
`endif
  output logic [31:0]   q,
  output logic [31:0]   q_r
);

  // Constant program image. The explicit bound test and the case default
  // make every unprogrammed index read zero, so q is never X or Z.
  function automatic logic [31:0] rom_word(input logic [AW-1:0] idx);
    logic [31:0] w;
    w = 32'h0000_0000;
    if (int'(idx) < N_PROG) begin
      case (idx)
        6'd0:  w = 32'hf8000001;
        6'd1:  w = 32'hf8008002;
        6'd2:  w = 32'hf8000203;
        6'd3:  w = 32'h8b050083;
        6'd4:  w = 32'hf8018003;
        6'd5:  w = 32'hcb050083;
        6'd6:  w = 32'hf8020003;
        6'd7:  w = 32'hcb0a03e4;
        6'd8:  w = 32'hf8028004;
        6'd9:  w = 32'h8b040064;
        6'd10: w = 32'hf8030004;
        6'd11: w = 32'hcb030025;
        6'd12: w = 32'hf8038005;
        6'd13: w = 32'h8a1f0145;
        6'd14: w = 32'hf8040005;
        6'd15: w = 32'h8a030145;
        6'd16: w = 32'hf8048005;
        6'd17: w = 32'h8a140294;
        6'd18: w = 32'hf8050014;
        6'd19: w = 32'haa1f0166;
        6'd20: w = 32'hf8058006;
        6'd21: w = 32'haa030166;
        6'd22: w = 32'hf8060006;
        6'd23: w = 32'hf840000c;
        6'd24: w = 32'h8b1f0187;
        6'd25: w = 32'hf8068007;
        6'd26: w = 32'hf807000c;
        6'd27: w = 32'h8b0e01bf;
        6'd28: w = 32'hf807801f;
        6'd29: w = 32'hb4000040;
        6'd30: w = 32'hf8080015;
        6'd31: w = 32'hf8088015;
        6'd32: w = 32'h8b0103e2;
        6'd33: w = 32'hcb010042;
        6'd34: w = 32'h8b0103f8;
        6'd35: w = 32'hf8090018;
        6'd36: w = 32'h8b080000;
        6'd37: w = 32'hb4ffff82;
        6'd38: w = 32'hf809001e;
        6'd39: w = 32'h8b1e03de;
        6'd40: w = 32'hcb1503f5;
        6'd41: w = 32'h8b1403de;
        6'd42: w = 32'hf85f83d9;
        6'd43: w = 32'h8b1e03de;
        6'd44: w = 32'h8b1003de;
        6'd45: w = 32'hf81f83d9;
        6'd46: w = 32'hb400001f;
        default: w = 32'h0000_0000;
      endcase
    end
    return w;
  endfunction

  // NOTE: the always_comb block assigns q on every path, so no latch is
  // inferred. The read path depends only on addr and never on clk or rst_n.
  always_comb begin
    q = rom_word(addr);
  end

`ifdef IMEM_OOB_FLAG_EN
  assign oob = (int'(addr) >= N_PROG);
`endif

  // NOTE: the ROM contents are constants, so they need no reset. Only the
  // output register is reset. It uses a non-blocking assignment, which keeps
  // the one-cycle latency free of race conditions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_r <= 32'h0000_0000;
    else        q_r <= q;
  end

endmodule

// File: tb/tb_imem_rom.sv
// -----------------------------------------------------------------------------
// tb_imem_rom
//
// Self-checking bench for imem_rom. The reference model is the published
// program table, indexed directly. Any index at or past the program length
// reads zero. The register is modelled as "value of the address presented
// before the last rising edge".
// -----------------------------------------------------------------------------
module tb_imem_rom;

  localparam int NP = 47;

  logic        clk;
  logic        rst_n;
  logic [5:0]  addr;
  logic [31:0] q;
  logic [31:0] q_r;
`ifdef IMEM_OOB_FLAG_EN
  logic        oob;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  bit clk_en = 1'b0;

  logic [31:0] prog [0:NP-1] = '{
    32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083, 32'hf8018003,
    32'hcb050083, 32'hf8020003, 32'hcb0a03e4, 32'hf8028004, 32'h8b040064,
    32'hf8030004, 32'hcb030025, 32'hf8038005, 32'h8a1f0145, 32'hf8040005,
    32'h8a030145, 32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
    32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c, 32'h8b1f0187,
    32'hf8068007, 32'hf807000c, 32'h8b0e01bf, 32'hf807801f, 32'hb4000040,
    32'hf8080015, 32'hf8088015, 32'h8b0103e2, 32'hcb010042, 32'h8b0103f8,
    32'hf8090018, 32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
    32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de, 32'h8b1003de,
    32'hf81f83d9, 32'hb400001f
  };

  function automatic logic [31:0] ref_q(input int a);
    return (a < NP) ? prog[a] : 32'h0;
  endfunction

  imem_rom dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
`ifdef IMEM_OOB_FLAG_EN
    .oob   (oob),
`endif
    .q     (q),
    .q_r   (q_r)
  );

  // The clock is gated so that the address sweep runs with no edges at all.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_r;
    int a;

    // Reset state. No clock runs yet.
    rst_n = 1'b0;
    addr  = 6'd0;
    #1;
    chk("reset_q_r", q_r, 32'h0);

    // Combinational sweep of every index, with no clock edges.
    for (int i = 0; i < 64; i++) begin
      addr = 6'(i);
      #5;
      chk($sformatf("sweep_q[%0d]", i), q, ref_q(i));
`ifdef IMEM_OOB_FLAG_EN
      chk($sformatf("sweep_oob[%0d]", i), {31'h0, oob}, (i >= NP) ? 32'h1 : 32'h0);
`endif
    end
    chk("sweep_q_r_held", q_r, 32'h0);

    // Spot checks against literal values.
    addr = 6'd0;  #1; chk("spot_0",  q, 32'hf8000001);
    addr = 6'd29; #1; chk("spot_29", q, 32'hb4000040);
    addr = 6'd37; #1; chk("spot_37", q, 32'hb4ffff82);
    addr = 6'd46; #1; chk("spot_46", q, 32'hb400001f);
`ifdef IMEM_OOB_FLAG_EN
    chk("oob_46", {31'h0, oob}, 32'h0);
`endif
    addr = 6'd47; #1; chk("spot_47", q, 32'h0);
`ifdef IMEM_OOB_FLAG_EN
    chk("oob_47", {31'h0, oob}, 32'h1);
`endif
    addr = 6'd63; #1; chk("spot_63", q, 32'h0);
`ifdef IMEM_OOB_FLAG_EN
    chk("oob_63", {31'h0, oob}, 32'h1);
`endif

    // Clock runs while reset is held low: q_r stays 0 and q stays live.
    addr = 6'd3;
    clk_en = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_hold_q_r", q_r, 32'h0);
      chk("rst_hold_q", q, 32'h8b050083);
    end

    // Release reset between edges. q_r waits for the first rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_pre_edge", q_r, 32'h0);
    @(posedge clk); #1;
    chk("release_first_edge", q_r, 32'h8b050083);

    // Changing addr updates q at once; q_r waits for the next edge.
    @(negedge clk);
    addr = 6'd9;
    #1;
    chk("addr9_q", q, 32'h8b040064);
    chk("addr9_q_r_old", q_r, 32'h8b050083);
    @(posedge clk); #1;
    chk("addr9_q_r_new", q_r, 32'h8b040064);

    // Randomized addresses against the model, with one-cycle latency.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      a = int'($urandom_range(0, 63));
      addr = 6'(a);
      exp_r = ref_q(a);
      #1;
      chk($sformatf("rand_q[%0d]", a), q, ref_q(a));
      @(posedge clk); #1;
      chk($sformatf("rand_q_r[%0d]", a), q_r, exp_r);
    end

    // Reset asserted mid-cycle with q_r nonzero clears q_r with no edge.
    @(negedge clk);
    addr = 6'd0;
    @(posedge clk); #1;
    chk("pre_midrst_q_r", q_r, 32'hf8000001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_q_r", q_r, 32'h0);
    chk("midrst_q", q, 32'hf8000001);
    @(posedge clk); #1;
    chk("midrst_hold_q_r", q_r, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_midrst_q_r", q_r, 32'hf8000001);

    clk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
